morse_encoder_tx: RTL and testbench

- Transmit-side counterpart of the Morse letter decoder: accepts a letter number (1 = A … 26 = Z) and keys it out as a timed on/off Morse signal on a single line.
- Uses the same 8-bit packed symbol code internally that the receive path produces, so a letter keyed by this block decodes to the same number.
- Sits between the letter-selection front end (switches/buttons) and the LED/buzzer driver.

---
 rtl/morse_encoder_tx.sv | 171 +++++++++++++++++
 tb/tb_morse_encoder_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder_tx.sv
// morse_encoder_tx: keys a letter number (1 = A .. 26 = Z) out as a timed
// Morse on/off signal. Letters are held internally in the same 8-bit packed
// symbol code the receive-side decoder produces. That code is four 2-bit slots,
// right-aligned, with 00 = empty, 01 = dot and 11 = dash. The most-significant
// non-empty slot is sent first.
//
// Handshake: start is accepted only in a cycle where ready = 1. A start seen
// while ready = 0 is dropped with no queueing and no err. done and err are
// single-cycle pulses. All outputs come straight from flops.
module morse_encoder_tx #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] letter_num,
  output logic       ready,
  output logic       key_out,
  output logic       done,
  output logic       err
);

  // The counter must hold 3*UNIT_CYCLES-1, the longest reload value.
  localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] DOT_LOAD  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LOAD = CW'(3 * UNIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MARK = 2'd1;
  localparam logic [1:0] S_SGAP = 2'd2;
  localparam logic [1:0] S_LGAP = 2'd3;

  // state is the single observable FSM register.
  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic [7:0]    pat, pat_n;
  logic          done_n, err_n;

  logic [7:0]    lut_pat;
  logic [1:0]    lut_idx;
  logic [1:0]    idx_dec;

  // Letter table. It must match the decoder table bit-for-bit.
  // Returns 0 for invalid letter numbers.
  function automatic logic [7:0] letter_code(input logic [4:0] n);
    case (n)
      5'd1:  letter_code = 8'b00000111; // A .-
      5'd2:  letter_code = 8'b11010101; // B -...
      5'd3:  letter_code = 8'b11011101; // C -.-.
      5'd4:  letter_code = 8'b00110101; // D -..
      5'd5:  letter_code = 8'b00000001; // E .
      5'd6:  letter_code = 8'b01011101; // F ..-.
      5'd7:  letter_code = 8'b00111101; // G --.
      5'd8:  letter_code = 8'b01010101; // H ....
      5'd9:  letter_code = 8'b00000101; // I ..
      5'd10: letter_code = 8'b01111111; // J .---
      5'd11: letter_code = 8'b00110111; // K -.-
      5'd12: letter_code = 8'b01110101; // L .-..
      5'd13: letter_code = 8'b00001111; // M --
      5'd14: letter_code = 8'b00001101; // N -.
      5'd15: letter_code = 8'b00111111; // O ---
      5'd16: letter_code = 8'b01111101; // P .--.
      5'd17: letter_code = 8'b11110111; // Q --.-
      5'd18: letter_code = 8'b00011101; // R .-.
      5'd19: letter_code = 8'b00010101; // S ...
      5'd20: letter_code = 8'b00000011; // T -
      5'd21: letter_code = 8'b00010111; // U ..-
      5'd22: letter_code = 8'b01010111; // V ...-
      5'd23: letter_code = 8'b00011111; // W .--
      5'd24: letter_code = 8'b11010111; // X -..-
      5'd25: letter_code = 8'b11011111; // Y -.--
      5'd26: letter_code = 8'b11110101; // Z --..
      default: letter_code = 8'b00000000;
    endcase
  endfunction

  // Index of the highest non-empty slot, which is the first symbol to send.
  function automatic logic [1:0] top_slot(input logic [7:0] p);
    if (p[7:6] != 2'b00)      top_slot = 2'd3;
    else if (p[5:4] != 2'b00) top_slot = 2'd2;
    else if (p[3:2] != 2'b00) top_slot = 2'd1;
    else                      top_slot = 2'd0;
  endfunction

  // Mark length for a slot. Only 11 is a dash. The code 10 never comes out
  // of the table, and if it appears it is sent as a dot.
  function automatic logic [CW-1:0] sym_load(input logic [1:0] sym);
    sym_load = (sym == 2'b11) ? DASH_LOAD : DOT_LOAD;
  endfunction

  assign lut_pat = letter_code(letter_num);
  assign lut_idx = top_slot(lut_pat);
  assign idx_dec = idx - 2'd1;

  // Next-state logic. The counter is reloaded on every state entry and then
  // counts down to zero, so each state lasts reload+1 cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    pat_n   = pat;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (cnt != '0) cnt_n = cnt - CW'(1);
    case (state)
      S_IDLE: begin
        if (start) begin
          if (lut_pat != 8'd0) begin
            pat_n   = lut_pat;
            idx_n   = lut_idx;
            cnt_n   = sym_load(lut_pat[{lut_idx, 1'b0} +: 2]);
            state_n = S_MARK;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (cnt == '0) begin
          if (idx != 2'd0) begin
            state_n = S_SGAP;
            cnt_n   = DOT_LOAD;
          end else begin
            state_n = S_LGAP;
            cnt_n   = DASH_LOAD;
          end
        end
      end
      S_SGAP: begin
        if (cnt == '0) begin
          idx_n   = idx_dec;
          cnt_n   = sym_load(pat[{idx_dec, 1'b0} +: 2]);
          state_n = S_MARK;
        end
      end
      S_LGAP: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
          pat_n   = 8'd0;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs. Reset abandons any letter in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= 2'd0;
      pat     <= 8'd0;
      ready   <= 1'b1;
      key_out <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      pat     <= pat_n;
      ready   <= (state_n == S_IDLE);
      key_out <= (state_n == S_MARK);
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Bench for morse_encoder_tx. Expected waveforms are built from dot/dash
// strings for each letter. The bench checks the waveform cycle by cycle and
// also rebuilds the packed code from the measured mark lengths.
module tb_morse_encoder_tx;
  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] letter_num;
  logic       ready, key_out, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle expected {key_out, ready, done, err}.
  logic [3:0] exp_q[$];

  string morse_tab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                           "....", "..", ".---", "-.-", ".-..", "--", "-.",
                           "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                           "...-", ".--", "-..-", "-.--", "--.."};

  typedef struct {
    logic [4:0] letter;
    logic       exp_err;
    int         exp_busy;
  } vec_t;

  vec_t vecs[9];

  morse_encoder_tx #(.UNIT_CYCLES(U)) dut (
    .clk(clk), .reset(reset), .start(start), .letter_num(letter_num),
    .ready(ready), .key_out(key_out), .done(done), .err(err)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] obs();
    return {key_out, ready, done, err};
  endfunction

  function automatic logic [7:0] pattern_of(input string m);
    logic [7:0] p;
    p = 8'd0;
    for (int i = 0; i < m.len(); i++)
      p = {p[5:0], (m[i] == "-") ? 2'b11 : 2'b01};
    return p;
  endfunction

  // Send a valid letter, starting in the current cycle, which must be idle or a done cycle.
  // Return in the done cycle. noise: 0 = quiet, 1 = random starts while busy, 2 = start held while busy.
  task automatic send(input logic [4:0] l, input int noise);
    string      m;
    logic [7:0] rebuilt;
    logic [1:0] sym;
    int         run;
    m = morse_tab[l - 1];
    exp_q.delete();
    for (int i = 0; i < m.len(); i++) begin
      for (int c = 0; c < ((m[i] == "-") ? 3 * U : U); c++) exp_q.push_back(4'b1000);
      if (i < m.len() - 1)
        for (int c = 0; c < U; c++) exp_q.push_back(4'b0000);
    end
    for (int c = 0; c < 3 * U; c++) exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0110);
    letter_num = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    rebuilt = 8'd0;
    run = 0;
    while (exp_q.size() > 0) begin
      check($sformatf("wave %s", m), int'(obs()), int'(exp_q.pop_front()));
      if (key_out) run++;
      else if (run > 0) begin
        sym = (run == U) ? 2'b01 : (run == 3 * U) ? 2'b11 : 2'b10;
        rebuilt = {rebuilt[5:0], sym};
        run = 0;
      end
      if (exp_q.size() > 0) begin
        start = (noise == 2) || (noise == 1 && $urandom_range(0, 3) == 0);
        letter_num = 5'($urandom_range(0, 31));
        tick();
      end
    end
    start = 1'b0;
    check($sformatf("loopback %s", m), int'(rebuilt), int'(pattern_of(m)));
  endtask

  // Start with an invalid letter number. Expect an err pulse and no key activity.
  task automatic send_bad(input logic [4:0] l);
    letter_num = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("err pulse %0d", l), int'(obs()), int'(4'b0101));
    for (int c = 0; c < 3 * U; c++) begin
      tick();
      check($sformatf("after bad %0d", l), int'(obs()), int'(4'b0100));
    end
  endtask

  initial begin
    int busy;
    vecs[0] = '{5'd5,  1'b0, 16};
    vecs[1] = '{5'd1,  1'b0, 32};
    vecs[2] = '{5'd20, 1'b0, 24};
    vecs[3] = '{5'd2,  1'b0, 48};
    vecs[4] = '{5'd17, 1'b0, 64};
    vecs[5] = '{5'd9,  1'b0, 24};
    vecs[6] = '{5'd0,  1'b1, 0};
    vecs[7] = '{5'd27, 1'b1, 0};
    vecs[8] = '{5'd31, 1'b1, 0};

    // Reset
    reset = 1'b1;
    start = 1'b0;
    letter_num = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset values", int'(obs()), int'(4'b0100));
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("idle after reset", int'(obs()), int'(4'b0100));

    // Table-driven: err at N+1 and busy length
    for (int v = 0; v < 9; v++) begin
      letter_num = vecs[v].letter;
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("vec%0d err", v), int'(err), int'(vecs[v].exp_err));
      busy = 0;
      while (!ready && busy < 500) begin
        busy++;
        tick();
      end
      check($sformatf("vec%0d busy", v), busy, vecs[v].exp_busy);
      check($sformatf("vec%0d done", v), int'(done), vecs[v].exp_err ? 0 : 1);
      tick();
    end

    // Cycle-exact waveforms for E and A, starting from idle
    send(5'd5, 0);
    tick();
    send(5'd1, 0);
    tick();

    // B with start held and letter_num scrambled for the whole letter
    send(5'd2, 2);

    // Exhaustive back-to-back loopback, each start issued in the done cycle
    for (int l = 1; l <= 26; l++) send(5'(l), 1);
    tick();

    // Invalid letters
    send_bad(5'd0);
    send_bad(5'd27);

    // Reset in the middle of the first dash of Q
    letter_num = 5'd17;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("Q dash high", int'(key_out), 1);
    #3;
    reset = 1'b1;
    #1;
    check("async reset", int'(obs()), int'(4'b0100));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3 * U; c++) begin
      tick();
      check("post reset idle", int'(obs()), int'(4'b0100));
    end
    send(5'd20, 0);

    // Random letters, invalid starts and idle gaps
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 9) == 0)
        send_bad(($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(27, 31)));
      else
        send(5'($urandom_range(1, 26)), 1);
      if ($urandom_range(0, 2) == 0) begin
        tick();
        check("random idle", int'(obs()), int'(4'b0100));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
